// File: rtl/tictactoe_game_ctrl.sv
// Turn sequencer and board owner for a two-player 3x3 game.
// Latency: accepted move -> board updated in CHECK next cycle -> next turn/DONE one cycle later.
// Backpressure: move_ready only in X_TURN/O_TURN; moves presented elsewhere are dropped silently.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 pulse: clear board and begin a game (honoured in IDLE/DONE only)
//   move_valid/_player/_pos  move request (player 0 = X, 1 = O; pos 0..8 row-major)
//   move_ready            controller is waiting for a move from the player in turn
//   board_x, board_o      occupied cells per player (bit i = cell i)
//   turn                  00 none, 01 X to move, 10 O to move
//   illegal               1-cycle pulse after a rejected handshake
//   game_over, winner, forfeit  result reporting (winner 01 X, 10 O, 11 draw)
module tictactoe_game_ctrl #(
   parameter int TURN_TIMEOUT = 1000,
   parameter bit X_FIRST      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic       move_player,
   input  logic [3:0] move_pos,
   output logic       move_ready,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic [1:0] turn,
   output logic       illegal,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       forfeit
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      X_TURN = 3'd1,
      O_TURN = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int            TW     = $clog2(TURN_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TURN_TIMEOUT - 1);
   localparam state_t        FIRST  = X_FIRST ? X_TURN : O_TURN;

   state_t        state, state_nxt;
   logic [8:0]    bx_q, bo_q, bx_nxt, bo_nxt;
   logic [TW-1:0] timer_q, timer_nxt;
   logic          illegal_q, illegal_nxt;
   logic [1:0]    winner_q, winner_nxt;
   logic          forfeit_q, forfeit_nxt;
   logic          mover_q, mover_nxt;   // player of the move being evaluated in CHECK

   logic          in_turn;
   logic          player_ok;
   logic          take;
   logic          legal;
   logic [8:0]    cell_mask;
   logic [8:0]    occupied;
   logic [8:0]    check_board;

   function automatic logic has_line(input logic [8:0] b);
      has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
                 (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                 (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   // An out-of-range position yields an empty mask, which makes the move illegal.
   assign cell_mask   = (move_pos <= 4'd8) ? (9'd1 << move_pos) : 9'd0;
   assign occupied    = bx_q | bo_q;
   assign in_turn     = (state == X_TURN) || (state == O_TURN);
   assign player_ok   = (state == X_TURN) ? ~move_player : move_player;
   assign take        = move_valid & in_turn;
   assign legal       = take & player_ok & (cell_mask != 9'd0) & ((occupied & cell_mask) == 9'd0);
   assign check_board = mover_q ? bo_q : bx_q;

   always_comb begin
      state_nxt   = state;
      bx_nxt      = bx_q;
      bo_nxt      = bo_q;
      timer_nxt   = timer_q;
      illegal_nxt = 1'b0;
      winner_nxt  = winner_q;
      forfeit_nxt = forfeit_q;
      mover_nxt   = mover_q;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = FIRST;
               bx_nxt      = 9'd0;
               bo_nxt      = 9'd0;
               timer_nxt   = '0;
               winner_nxt  = 2'b00;
               forfeit_nxt = 1'b0;
            end
         end
         X_TURN, O_TURN: begin
            illegal_nxt = take & ~legal;
            if (legal) begin
               if (state == X_TURN) bx_nxt = bx_q | cell_mask;
               else                 bo_nxt = bo_q | cell_mask;
               mover_nxt = (state == O_TURN);
               state_nxt = CHECK;
               timer_nxt = '0;
            end else if (timer_q == T_LAST) begin
               // Idle (or only illegal attempts) for the whole budget: opponent wins.
               state_nxt   = DONE;
               winner_nxt  = (state == X_TURN) ? 2'b10 : 2'b01;
               forfeit_nxt = 1'b1;
            end else begin
               timer_nxt = timer_q + TW'(1);
            end
         end
         CHECK: begin
            // Line test runs before the full-board test so a 9th-move win is not a draw.
            if (has_line(check_board)) begin
               state_nxt  = DONE;
               winner_nxt = mover_q ? 2'b10 : 2'b01;
            end else if (&occupied) begin
               state_nxt  = DONE;
               winner_nxt = 2'b11;
            end else begin
               state_nxt = mover_q ? X_TURN : O_TURN;
            end
            timer_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bx_q      <= 9'd0;
         bo_q      <= 9'd0;
         timer_q   <= '0;
         illegal_q <= 1'b0;
         winner_q  <= 2'b00;
         forfeit_q <= 1'b0;
         mover_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         bx_q      <= bx_nxt;
         bo_q      <= bo_nxt;
         timer_q   <= timer_nxt;
         illegal_q <= illegal_nxt;
         winner_q  <= winner_nxt;
         forfeit_q <= forfeit_nxt;
         mover_q   <= mover_nxt;
      end
   end

   assign move_ready = in_turn;
   assign board_x    = bx_q;
   assign board_o    = bo_q;
   assign turn       = {state == O_TURN, state == X_TURN};
   assign illegal    = illegal_q;
   assign game_over  = (state == DONE);
   assign winner     = winner_q;
   assign forfeit    = forfeit_q;

endmodule
